fetch_unit: RTL and testbench

Instruction fetch stage directly upstream of the decoder. It keeps the PC and issues word fetches to instruction memory over a request/grant bus. Returned words go into a small in-order buffer, and the unit presents them to the decoder with a valid/ready handshake; the decoder's read enable is instr_valid_o & instr_ready_i. A redirect from execute flushes the buffer, drops any fetches still in flight, and restarts fetch at the new PC.

---
 rtl/riscv_pkg.sv | 26 ++
 rtl/fetch_fifo.sv | 63 ++++++
 rtl/fetch_unit.sv | 132 +++++++++++++
 tb/tb_fetch_unit.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end types and constants.
// Fetch-stage state and buffer-entry types live here so the fetch unit and its FIFO agree on them.
package riscv_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT,
    FETCH,
    DRAIN
  } t_fetch_state;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } t_fetch_entry;

  // Clears the byte-offset bits so the result is an instruction-aligned address.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~XLEN'(INSTR_BYTES - 1);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous in-order buffer between the memory response path and the decoder.
// Flush dominates push and pop; the head is read combinationally from storage.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int  DEPTH = 2,
  parameter type T     = t_fetch_entry,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          i_clk,
  input  logic          i_rstn,
  input  logic          i_push,
  input  T              i_data,
  input  logic          i_pop,
  input  logic          i_flush,
  output T              o_head,
  output logic [CW-1:0] o_count,
  output logic          o_full,
  output logic          o_empty
);

  T              r_mem [DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic          w_do_pop;

  // DEPTH is a power of two, so the pointers wrap on their own.
  assign w_do_pop = i_pop & ~o_empty;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      // NOTE: storage is reset here so the head reads as zero straight out of reset.
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      // NOTE: non-blocking assignments make every register update from pre-edge values.
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count <= r_count + CW'(i_push) - CW'(w_do_pop);
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word fetches over a req/gnt bus and
// buffers in-order responses for the decoder. A redirect flushes and restarts fetch.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            mem_req_o,
  output logic [XLEN-1:0] mem_addr_o,
  input  logic            mem_gnt_i,
  input  logic            mem_rvalid_i,
  input  logic [XLEN-1:0] mem_rdata_i,
  output logic            instr_valid_o,
  input  logic            instr_ready_i,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] pc_o
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  t_fetch_state    r_state;
  t_fetch_state    w_state_next;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_resp_pc;
  logic [CW-1:0]   r_outstanding;
  logic [CW-1:0]   r_discard;
  logic [CW-1:0]   w_outstanding_next;
  logic [CW-1:0]   w_discard_next;

  logic            w_xfer;
  logic            w_drop;
  logic            w_push;
  logic            w_pop;
  logic [XLEN-1:0] w_redirect_pc;
  t_fetch_entry    w_push_entry;
  t_fetch_entry    w_head;
  logic [CW-1:0]   w_fifo_count;
  logic            w_fifo_full;
  logic            w_fifo_empty;

  assign w_redirect_pc = word_align(redirect_pc_i);
  assign w_xfer        = mem_req_o & mem_gnt_i;
  assign w_drop        = mem_rvalid_i & (r_discard != '0);
  assign w_push        = mem_rvalid_i & ~w_drop & ~redirect_i;
  assign w_pop         = instr_valid_o & instr_ready_i;
  assign w_push_entry  = '{pc: r_resp_pc, instr: mem_rdata_i};

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    w_state_next       = r_state;
    mem_req_o          = 1'b0;
    w_outstanding_next = r_outstanding;
    w_discard_next     = r_discard;

    // Credit check: in-flight fetches plus buffered words never exceed the buffer depth.
    if (r_state == FETCH && !redirect_i &&
        ((CW+1)'(r_outstanding) + (CW+1)'(w_fifo_count) < (CW+1)'(FIFO_DEPTH))) begin
      mem_req_o = 1'b1;
    end

    w_outstanding_next = r_outstanding + CW'(w_xfer) - CW'(mem_rvalid_i);

    // Discarded fetches are a subset of outstanding ones, so on a redirect every
    // response still in flight after this cycle becomes stale.
    if (redirect_i) begin
      w_discard_next = w_outstanding_next;
    end else begin
      w_discard_next = r_discard - CW'(w_drop);
    end

    case (r_state)
      BOOT:    w_state_next = FETCH;
      FETCH:   if (redirect_i && w_discard_next != '0) w_state_next = DRAIN;
      DRAIN:   if (w_discard_next == '0) w_state_next = FETCH;
      default: w_state_next = BOOT;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state       <= BOOT;
      r_pc          <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_outstanding <= '0;
      r_discard     <= '0;
    end else begin
      r_state       <= w_state_next;
      r_outstanding <= w_outstanding_next;
      r_discard     <= w_discard_next;
      if (redirect_i) begin
        r_pc      <= w_redirect_pc;
        r_resp_pc <= w_redirect_pc;
      end else begin
        if (w_xfer) r_pc      <= r_pc + XLEN'(INSTR_BYTES);
        if (w_push) r_resp_pc <= r_resp_pc + XLEN'(INSTR_BYTES);
      end
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (t_fetch_entry)
  ) u_fifo (
    .i_clk   (clk_i),
    .i_rstn  (rstn_i),
    .i_push  (w_push),
    .i_data  (w_push_entry),
    .i_pop   (w_pop),
    .i_flush (redirect_i),
    .o_head  (w_head),
    .o_count (w_fifo_count),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  assign mem_addr_o    = r_pc;
  assign instr_valid_o = ~w_fifo_empty;
  assign instr_o       = w_head.instr;
  assign pc_o          = w_head.pc;

  a_no_overflow : assert property (@(posedge clk_i) disable iff (!rstn_i)
    !(w_push && w_fifo_full && !w_pop));

  a_outstanding_bound : assert property (@(posedge clk_i) disable iff (!rstn_i)
    (CW+1)'(r_outstanding) <= (CW+1)'(FIFO_DEPTH));

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: an in-order memory with random grant/latency and a
// queue-based reference model of in-flight fetches and buffered instructions.
module tb_fetch_unit;

  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          stale;
  } fl_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b1;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i = 1'b0;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic        instr_valid_o;
  logic        instr_ready_i = 1'b0;
  logic [31:0] instr_o;
  logic [31:0] pc_o;

  fetch_unit #(
    .RESET_PC   (RESET_PC),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk_i         (clk_i),
    .rstn_i        (rstn_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .mem_req_o     (mem_req_o),
    .mem_addr_o    (mem_addr_o),
    .mem_gnt_i     (mem_gnt_i),
    .mem_rvalid_i  (mem_rvalid_i),
    .mem_rdata_i   (mem_rdata_i),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready_i),
    .instr_o       (instr_o),
    .pc_o          (pc_o)
  );

  always #5 clk_i = ~clk_i;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model state.
  fl_t         inflight[$];
  ent_t        fifo_q[$];
  logic [31:0] fetch_pc = RESET_PC;
  bit          boot = 1'b0;
  int          cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return addr * 32'h9E37_79B1 + 32'h1234_5677;
  endfunction

  function automatic int stale_count();
    int n = 0;
    foreach (inflight[i]) if (inflight[i].stale) n++;
    return n;
  endfunction

  // One clock cycle: drive inputs at the falling edge, check outputs, advance the model.
  task automatic cycle(input bit gnt, input bit rdy, input bit redir,
                       input logic [31:0] rpc, input int lat);
    bit   rv, exp_req, exp_valid;
    fl_t  head;
    ent_t e;
    @(negedge clk_i);
    rv = (inflight.size() > 0) && (inflight[0].due <= cyc);
    mem_gnt_i     = gnt;
    instr_ready_i = rdy;
    redirect_i    = redir;
    redirect_pc_i = rpc;
    mem_rvalid_i  = rv;
    mem_rdata_i   = rv ? mem_word(inflight[0].addr) : $urandom;
    #1;
    exp_req   = !boot && !redir && (stale_count() == 0) &&
                (inflight.size() + fifo_q.size() < DEPTH);
    exp_valid = (fifo_q.size() > 0);
    check("mem_req", 32'(mem_req_o), 32'(exp_req));
    check("mem_addr", mem_addr_o, fetch_pc);
    check("instr_valid", 32'(instr_valid_o), 32'(exp_valid));
    if (exp_valid) begin
      check("pc", pc_o, fifo_q[0].pc);
      check("instr", instr_o, fifo_q[0].instr);
    end
    if (rv) head = inflight.pop_front();
    if (redir) begin
      fifo_q.delete();
      foreach (inflight[i]) inflight[i].stale = 1'b1;
      fetch_pc = rpc & ~32'h3;
    end else begin
      if (exp_valid && rdy) void'(fifo_q.pop_front());
      if (rv && !head.stale) begin
        e.pc    = head.addr;
        e.instr = mem_word(head.addr);
        fifo_q.push_back(e);
      end
      if (exp_req && gnt) begin
        fl_t f;
        f.addr  = fetch_pc;
        f.due   = cyc + lat;
        f.stale = 1'b0;
        inflight.push_back(f);
        fetch_pc += 32'd4;
      end
    end
    boot = 1'b0;
    cyc++;
  endtask

  // Asserts reset away from any clock edge, checks the immediate output response,
  // then releases just after a rising edge so the next cycle is the BOOT cycle.
  task automatic apply_reset();
    #2;
    rstn_i       = 1'b0;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    redirect_i   = 1'b0;
    #1;
    check("rst_mem_req", 32'(mem_req_o), 32'd0);
    check("rst_valid", 32'(instr_valid_o), 32'd0);
    check("rst_addr", mem_addr_o, RESET_PC);
    check("rst_instr", instr_o, 32'd0);
    check("rst_pc", pc_o, 32'd0);
    inflight.delete();
    fifo_q.delete();
    fetch_pc = RESET_PC;
    repeat (2) @(posedge clk_i);
    #2;
    rstn_i = 1'b1;
    boot   = 1'b1;
  endtask

  // Runs until the model holds a word, then checks the DUT head PC one edge later.
  task automatic expect_first(input string tag, input logic [31:0] exp_pc);
    bit found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (fifo_q.size() > 0) begin
        found = 1'b1;
        break;
      end
      cycle(1'b1, 1'b0, 1'b0, '0, 1);
    end
    check({tag, "_found"}, 32'(found), 32'd1);
    @(posedge clk_i);
    #1;
    check({tag, "_valid"}, 32'(instr_valid_o), 32'd1);
    check({tag, "_pc"}, pc_o, exp_pc);
    check({tag, "_instr"}, instr_o, mem_word(exp_pc));
  endtask

  task automatic fill_inflight(input int lat);
    for (int i = 0; i < 20; i++) begin
      if (inflight.size() == DEPTH && stale_count() == 0 && fifo_q.size() == 0) break;
      cycle(1'b1, 1'b1, 1'b0, '0, lat);
    end
    check("two_inflight", 32'(inflight.size()), 32'(DEPTH));
  endtask

  initial begin
    bit hit;

    #1;
    apply_reset();

    // Streaming with a one-cycle memory, full grant and ready.
    repeat (14) cycle(1'b1, 1'b1, 1'b0, '0, 1);

    // Decoder stalls: requests stop at the credit limit, head stays put, then resumes.
    repeat (8) cycle(1'b1, 1'b0, 1'b0, '0, 1);
    repeat (10) cycle(1'b1, 1'b1, 1'b0, '0, 1);

    // Two fetches in flight on a slow memory, then a redirect drops both responses.
    cycle(1'b1, 1'b1, 1'b1, 32'h0000_0000, 1);
    repeat (3) cycle(1'b1, 1'b1, 1'b0, '0, 1);
    fill_inflight(3);
    cycle(1'b1, 1'b1, 1'b1, 32'h0000_0100, 3);
    expect_first("redir_late", 32'h0000_0100);
    repeat (6) cycle(1'b1, 1'b1, 1'b0, '0, 1);

    // Redirect coinciding with a response and a pop.
    hit = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (inflight.size() > 0 && inflight[0].due <= cyc && fifo_q.size() > 0) begin
        cycle(1'b1, 1'b1, 1'b1, 32'h0000_0300, 1);
        hit = 1'b1;
        break;
      end
      cycle(1'b1, 1'b1, 1'b0, '0, 1);
    end
    check("redir_rv_pop_seen", 32'(hit), 32'd1);
    @(posedge clk_i);
    #1;
    check("redir_valid_low", 32'(instr_valid_o), 32'd0);
    expect_first("redir_rv", 32'h0000_0300);

    // Unaligned redirect target is forced to a word address.
    cycle(1'b1, 1'b1, 1'b1, 32'h0000_0103, 1);
    @(posedge clk_i);
    #1;
    check("redir_align", mem_addr_o, 32'h0000_0100);
    repeat (4) cycle(1'b1, 1'b1, 1'b0, '0, 1);

    // Second redirect during DRAIN: only the latest target is delivered.
    fill_inflight(3);
    cycle(1'b1, 1'b1, 1'b1, 32'h0000_0180, 3);
    cycle(1'b1, 1'b1, 1'b1, 32'h0000_0200, 3);
    expect_first("redir_drain", 32'h0000_0200);
    repeat (4) cycle(1'b1, 1'b1, 1'b0, '0, 1);

    // PC wraps from the top of the address space.
    cycle(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC, 1);
    hit = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 1'b1, 1'b0, '0, 1);
      if (fetch_pc == 32'h0) begin
        hit = 1'b1;
        break;
      end
    end
    check("wrap_seen", 32'(hit), 32'd1);
    @(posedge clk_i);
    #1;
    check("wrap_addr", mem_addr_o, 32'h0000_0000);
    repeat (6) cycle(1'b1, 1'b1, 1'b0, '0, 1);

    // Randomised traffic with a reset asserted in the middle of a burst.
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) apply_reset();
      cycle($urandom_range(3) != 0, $urandom_range(9) < 7, $urandom_range(31) == 0,
            $urandom, int'($urandom_range(4, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
